puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Controller wrapped around the delay PUF core; it sits directly upstream and downstream of it.
- On a start request it generates a sequence of challenges from an LFSR seeded by software.
- For each challenge it drives the PUF run pulse and captures the PUF result bit.
- It assembles the captured bits into a RESP_BITS-wide response word, which is presented to the logic-analyser/wishbone side with a done pulse.

Parameters:
- LENGTH, 8: challenge width; must equal the PUF core stage count.
- RESP_BITS, 32: number of response bits per start; range 2..64.
- TAPS, 8'hB8: Galois LFSR feedback mask, LENGTH bits wide.
- SETTLE_CYCLES, 4: cycles puf_run is held low with the new challenge applied; must be ≥3.
- EVAL_CYCLES, 8: cycles puf_run is held high before sampling; must be ≥5 (covers 2 run-sync flops + chain + 2 result-sync flops).

Ports:
- clk, in, 1: single clock for all state.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: single-cycle request; sampled only in IDLE.
- seed, in, LENGTH: first challenge; sampled on accepted start.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse when response is updated.
- response, out, RESP_BITS: last completed response word.
- puf_challenge, out, LENGTH: to PUF a_challenge.
- puf_run, out, 1: to PUF a_run.
- puf_result, in, 1: from PUF result (already synchronised inside the PUF).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; busy=0, done=0, response=0, puf_challenge=0, puf_run=0.
  - Counters and LFSR are cleared.
  - Reset mid-operation aborts immediately; no partial response is published.
- Synchronous reset is not used as run-gating. puf_run is a registered output.
- FSM states: IDLE, SETTLE, EVAL, DONE.
- IDLE:
  - start=1 → load LFSR with seed, or with 1 if seed==0; clear bit and cycle counters; go to SETTLE.
  - start while not in IDLE is ignored, with no queuing.
- SETTLE: puf_challenge=LFSR state, puf_run=0, for exactly SETTLE_CYCLES cycles, then go to EVAL.
- EVAL:
  - puf_run=1 for exactly EVAL_CYCLES cycles; challenge stays unchanged.
  - On the edge ending the last EVAL cycle, sample puf_result and shift it into the internal register: shreg <= {shreg[RESP_BITS-2:0], bit}. The first-evaluated bit therefore ends in response[RESP_BITS-1].
  - On that same edge, puf_run returns to 0.
  - If bit_cnt==RESP_BITS-1, go to DONE. Otherwise increment bit_cnt, advance the LFSR, and go to SETTLE.
- LFSR advance (Galois, right shift): next = (s>>1) ^ (s[0] ? TAPS : 0).
- DONE (1 cycle):
  - response <= final shreg; done=1; busy=0; return to IDLE.
  - A start in the DONE cycle is ignored.
- response holds its value until the next DONE or reset.
- Busy duration is RESP_BITS×(SETTLE_CYCLES+EVAL_CYCLES) cycles (×3 with the optional feature).
- Wrap-around: the LFSR may repeat within a long sequence; this is permitted and no special handling is done.
- Counter widths: $clog2 of their maxima, with a minimum of 1 bit.

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- When defined:
  - Each challenge is evaluated 3 times, each as a full SETTLE+EVAL period with the same challenge.
  - A 2-bit ones counter accumulates the samples; the bit shifted in is 1 iff ≥2 of 3 samples are 1.
  - The LFSR advances only after the third evaluation.
  - Busy duration triples.
- When undefined: a single evaluation per challenge, and no vote logic or rep counter is synthesised.

Test Plan:
- Bench PUF model: result = ^challenge, delayed 4 clk after run rises.
- Test 1, basic sequence:
  - Stimulus: RESP_BITS=8, SETTLE=4, EVAL=8, seed=8'h01, start pulse.
  - Expected: challenge sequence 01,B8,5C,2E,17,B3,E1,C8; busy high for 96 cycles; done pulse; response=8'h85.
- Test 2, zero seed:
  - Stimulus: seed=8'h00.
  - Expected: first challenge 8'h01; result identical to Test 1 (8'h85).
- Test 3, start while busy:
  - Stimulus: start re-pulsed at cycles 10 and 50 after the first start, and again in the DONE cycle.
  - Expected: exactly one done; response=8'h85; busy low after done.
- Test 4, reset mid-operation:
  - Stimulus: reset_n low at cycle 40 of a run.
  - Expected: next cycle busy=0, puf_run=0, response=0, no done.
  - Then a new start with seed=8'h01 gives 8'h85.
- Test 5, run waveform:
  - Check puf_run is low for 4 cycles and high for 8 cycles per bit, and puf_challenge never changes while puf_run=1.
- Test 6, PUF_MAJORITY_VOTE_EN:
  - Stimulus: model inverts its result on the 2nd evaluation of every challenge.
  - Expected: response=8'h85; busy for 288 cycles.
  - Without the macro and with an inverting model (all evaluations): response=8'h7A.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for a delay PUF: LFSR challenges, run pulse timing, response assembly.
// Optional build macro PUF_MAJORITY_VOTE_EN evaluates each challenge 3 times and keeps the majority bit.
module puf_challenge_sequencer #(
  parameter int               LENGTH        = 8,
  parameter int               RESP_BITS     = 32,
  parameter logic [LENGTH-1:0] TAPS         = 8'hB8,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               EVAL_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LENGTH-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response,
  output logic [LENGTH-1:0]    puf_challenge,
  output logic                 puf_run,
  input  logic                 puf_result
);

  localparam int CYC_MAX = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int BIT_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] EVAL_LAST   = CYC_W'(EVAL_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(RESP_BITS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, EVAL, DONE} state_t;

  state_t                state_reg;
  logic [CYC_W-1:0]      cyc_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [LENGTH-1:0]     lfsr_reg;
  logic [LENGTH-1:0]     lfsr_next;
  logic [RESP_BITS-1:0]  shreg_reg;
  logic [RESP_BITS-1:0]  shreg_next;
  logic                  sample_bit;

  // Galois right-shift step: feedback bit is the LSB shifted out.
  for (genvar gi = 0; gi < LENGTH; gi++) begin : g_lfsr
    if (gi == LENGTH - 1) begin : g_top
      assign lfsr_next[gi] = lfsr_reg[0] & TAPS[gi];
    end else begin : g_mid
      assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
    end
  end

`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0] rep_reg;
  logic [1:0] ones_reg;
  assign sample_bit = (({1'b0, ones_reg} + {2'b00, puf_result}) >= 3'd2);
`else
  assign sample_bit = puf_result;
`endif

  assign shreg_next = {shreg_reg[RESP_BITS-2:0], sample_bit};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cyc_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      lfsr_reg      <= '0;
      shreg_reg     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response      <= '0;
      puf_challenge <= '0;
      puf_run       <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      rep_reg       <= '0;
      ones_reg      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR, so substitute 1.
            lfsr_reg      <= (seed == '0) ? LENGTH'(1) : seed;
            puf_challenge <= (seed == '0) ? LENGTH'(1) : seed;
            cyc_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            busy          <= 1'b1;
            state_reg     <= SETTLE;
`ifdef PUF_MAJORITY_VOTE_EN
            rep_reg       <= '0;
            ones_reg      <= '0;
`endif
          end
        end

        SETTLE: begin
          if (cyc_cnt_reg == SETTLE_LAST) begin
            cyc_cnt_reg <= '0;
            puf_run     <= 1'b1;
            state_reg   <= EVAL;
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end

        EVAL: begin
          if (cyc_cnt_reg == EVAL_LAST) begin
            cyc_cnt_reg <= '0;
            puf_run     <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            if (rep_reg != 2'd2) begin
              // Re-evaluate the same challenge; accumulate this sample.
              rep_reg   <= rep_reg + 1'b1;
              ones_reg  <= ones_reg + {1'b0, puf_result};
              state_reg <= SETTLE;
            end else begin
              rep_reg   <= '0;
              ones_reg  <= '0;
`endif
              shreg_reg <= shreg_next;
              if (bit_cnt_reg == BIT_LAST) begin
                response  <= shreg_next;
                done      <= 1'b1;
                busy      <= 1'b0;
                state_reg <= DONE;
              end else begin
                bit_cnt_reg   <= bit_cnt_reg + 1'b1;
                lfsr_reg      <= lfsr_next;
                puf_challenge <= lfsr_next;
                state_reg     <= SETTLE;
              end
`ifdef PUF_MAJORITY_VOTE_EN
            end
`endif
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer with a behavioural parity PUF model.
// Honours PUF_MAJORITY_VOTE_EN to select the triple-evaluation expectations.
module tb_puf_challenge_sequencer;

  localparam int RB     = 8;
  localparam int SETTLE = 4;
  localparam int EVAL   = 8;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int REPS   = 3;
`else
  localparam int REPS   = 1;
`endif
  localparam int BUSY_LEN = RB * (SETTLE + EVAL) * REPS;
  localparam int TIMEOUT  = 2 * BUSY_LEN + 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [7:0]    seed;
  logic          busy;
  logic          done;
  logic [RB-1:0] response;
  logic [7:0]    puf_challenge;
  logic          puf_run;
  logic          puf_result;

  int errors = 0;
  int checks = 0;

  puf_challenge_sequencer #(
    .LENGTH(8), .RESP_BITS(RB), .TAPS(8'hB8), .SETTLE_CYCLES(SETTLE), .EVAL_CYCLES(EVAL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
    .busy(busy), .done(done), .response(response),
    .puf_challenge(puf_challenge), .puf_run(puf_run), .puf_result(puf_result)
  );

  always #5 clk = ~clk;

  // PUF model: parity of the challenge, valid 4 clocks after run rises, noise before that.
  int run_age    = 0;
  int eval_total = 0;
  int eval_base  = 0;
  int puf_mode   = 0;  // 0 normal, 1 invert all, 2 invert 2nd evaluation of each challenge

  always @(posedge clk) begin
    if (puf_run === 1'b1) begin
      if (run_age == 0) eval_total <= eval_total + 1;
      run_age <= run_age + 1;
    end else begin
      run_age <= 0;
    end
  end

  always @(negedge clk) begin
    int rel;
    bit inv;
    rel = eval_total - eval_base;
    inv = (puf_mode == 1) || (puf_mode == 2 && (rel % 3) == 2);
    if (run_age >= 4) puf_result <= (^puf_challenge) ^ inv;
    else              puf_result <= 1'($urandom_range(0, 1));
  end

  // Reference model derived from the sequence rules.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] model_chal(input logic [7:0] sd, input int idx);
    logic [7:0] s;
    s = (sd == 8'h00) ? 8'h01 : sd;
    for (int i = 0; i < idx; i++) s = lfsr_step(s);
    return s;
  endfunction

  function automatic logic [RB-1:0] model_resp(input logic [7:0] sd, input int mode);
    logic [7:0]    s;
    logic [RB-1:0] r;
    int            ones;
    bit            p;
    s = (sd == 8'h00) ? 8'h01 : sd;
    r = '0;
    for (int i = 0; i < RB; i++) begin
      ones = 0;
      for (int k = 0; k < REPS; k++) begin
        p = ^s;
        if (mode == 1 || (mode == 2 && k == 1)) p = !p;
        ones += int'(p);
      end
      r = {r[RB-2:0], (2 * ones > REPS)};
      s = lfsr_step(s);
    end
    return r;
  endfunction

  // Run observations gathered by do_run.
  logic [7:0]    chal_q[$];
  int            busy_cycles, done_count, extra_busy, hi_bad, lo_bad, hi_segs, chal_run_bad;
  logic [RB-1:0] resp_seen;

  task automatic do_run(input logic [7:0] sd, input bit pulse_busy);
    int         cyc, hi_len, lo_len;
    logic [7:0] rise_chal;
    bit         prev_run;
    chal_q.delete();
    busy_cycles = 0; done_count = 0; extra_busy = 0;
    hi_bad = 0; lo_bad = 0; hi_segs = 0; chal_run_bad = 0;
    resp_seen = '0; hi_len = 0; lo_len = 0; prev_run = 0; rise_chal = '0;
    @(negedge clk);
    eval_base = eval_total;
    seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed = 8'($urandom);
    cyc = 1;
    while (done_count == 0) begin
      if (cyc > TIMEOUT) begin
        checks++; errors++;
        $display("FAIL timeout: no done after %0d cycles (seed %h)", cyc, sd);
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin done_count++; resp_seen = response; end
      if (puf_run === 1'b1) begin
        if (!prev_run) begin
          chal_q.push_back(puf_challenge);
          rise_chal = puf_challenge;
          if (lo_len != SETTLE) lo_bad++;
          lo_len = 0;
        end else if (puf_challenge !== rise_chal) begin
          chal_run_bad++;
        end
        hi_len++;
      end else begin
        if (prev_run) begin
          hi_segs++;
          if (hi_len != EVAL) hi_bad++;
          hi_len = 0;
        end
        if (busy === 1'b1) lo_len++;
      end
      prev_run = (puf_run === 1'b1);
      start = pulse_busy && (cyc == 10 || cyc == 50 || done_count != 0);
      seed = 8'($urandom);
      if (done_count == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (busy === 1'b1) extra_busy++;
      if (done === 1'b1) done_count++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; seed = 8'h00; puf_mode = 0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (response !== '0) begin errors++; $display("FAIL reset_response: got %h want 0", response); end
    checks++; if (puf_challenge !== 8'h00) begin errors++; $display("FAIL reset_challenge: got %h want 00", puf_challenge); end
    checks++; if (puf_run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", puf_run); end
    reset_n = 1'b1;
    $display("reset: busy=%b done=%b response=%h", busy, done, response);
  endtask

  task automatic test_basic();
    logic [7:0] tbl [8];
    tbl = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};
    puf_mode = 0;
    do_run(8'h01, 1'b0);
    checks++; if (resp_seen !== 8'h85) begin errors++; $display("FAIL basic_response: got %h want 85", resp_seen); end
    checks++; if (response !== 8'h85) begin errors++; $display("FAIL basic_hold: got %h want 85", response); end
    checks++; if (busy_cycles != BUSY_LEN) begin errors++; $display("FAIL basic_busy_len: got %0d want %0d", busy_cycles, BUSY_LEN); end
    checks++; if (done_count != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
    checks++; if (chal_q.size() != RB * REPS) begin errors++; $display("FAIL basic_eval_count: got %0d want %0d", chal_q.size(), RB * REPS); end
    for (int j = 0; j < chal_q.size() && j < RB * REPS; j++) begin
      checks++;
      if (chal_q[j] !== tbl[j / REPS]) begin
        errors++; $display("FAIL basic_challenge[%0d]: got %h want %h", j, chal_q[j], tbl[j / REPS]);
      end
    end
    $display("basic: seed=01 response=%h busy=%0d", resp_seen, busy_cycles);
  endtask

  task automatic test_zero_seed();
    puf_mode = 0;
    do_run(8'h00, 1'b0);
    checks++; if (chal_q.size() == 0 || chal_q[0] !== 8'h01) begin
      errors++; $display("FAIL zero_seed_first: got %h want 01", (chal_q.size() != 0) ? chal_q[0] : 8'hxx);
    end
    checks++; if (resp_seen !== 8'h85) begin errors++; $display("FAIL zero_seed_response: got %h want 85", resp_seen); end
    $display("zero_seed: response=%h", resp_seen);
  endtask

  task automatic test_start_while_busy();
    puf_mode = 0;
    do_run(8'h01, 1'b1);
    checks++; if (done_count != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d want 1", done_count); end
    checks++; if (resp_seen !== 8'h85) begin errors++; $display("FAIL busy_start_response: got %h want 85", resp_seen); end
    checks++; if (extra_busy != 0) begin errors++; $display("FAIL busy_start_after_done: busy cycles %0d want 0", extra_busy); end
    $display("start_while_busy: done_count=%0d response=%h", done_count, resp_seen);
  endtask

  task automatic test_reset_mid_run();
    int late_done, late_busy;
    puf_mode = 0;
    @(negedge clk);
    eval_base = eval_total;
    seed = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (puf_run !== 1'b0) begin errors++; $display("FAIL midreset_run: got %b want 0", puf_run); end
    checks++; if (response !== '0) begin errors++; $display("FAIL midreset_response: got %h want 0", response); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
    reset_n = 1'b1;
    late_done = 0; late_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) late_done++;
      if (busy === 1'b1) late_busy++;
    end
    checks++; if (late_done != 0 || late_busy != 0) begin
      errors++; $display("FAIL midreset_idle: done=%0d busy=%0d want 0/0", late_done, late_busy);
    end
    do_run(8'h01, 1'b0);
    checks++; if (resp_seen !== 8'h85) begin errors++; $display("FAIL midreset_rerun: got %h want 85", resp_seen); end
    $display("reset_mid_run: rerun response=%h", resp_seen);
  endtask

  task automatic test_run_waveform();
    puf_mode = 0;
    do_run(8'($urandom), 1'b0);
    checks++; if (hi_segs != RB * REPS) begin errors++; $display("FAIL wave_segments: got %0d want %0d", hi_segs, RB * REPS); end
    checks++; if (hi_bad != 0) begin errors++; $display("FAIL wave_high_len: %0d bad segments want 0", hi_bad); end
    checks++; if (lo_bad != 0) begin errors++; $display("FAIL wave_low_len: %0d bad segments want 0", lo_bad); end
    checks++; if (chal_run_bad != 0) begin errors++; $display("FAIL wave_chal_stable: %0d changes want 0", chal_run_bad); end
    $display("run_waveform: high segments=%0d", hi_segs);
  endtask

  task automatic test_random_seeds();
    logic [7:0]    sd;
    logic [RB-1:0] exp_r;
    int            bad;
    puf_mode = 0;
    for (int n = 0; n < 5; n++) begin
      sd = 8'($urandom);
      do_run(sd, 1'b0);
      exp_r = model_resp(sd, 0);
      checks++; if (resp_seen !== exp_r) begin errors++; $display("FAIL random_response seed=%h: got %h want %h", sd, resp_seen, exp_r); end
      bad = 0;
      for (int j = 0; j < chal_q.size(); j++)
        if (chal_q[j] !== model_chal(sd, j / REPS)) bad++;
      checks++; if (bad != 0 || chal_q.size() != RB * REPS) begin
        errors++; $display("FAIL random_challenges seed=%h: %0d wrong of %0d", sd, bad, chal_q.size());
      end
      $display("random: seed=%h response=%h expected=%h", sd, resp_seen, exp_r);
    end
  endtask

  task automatic test_inverting_puf();
    logic [RB-1:0] exp_r;
`ifdef PUF_MAJORITY_VOTE_EN
    puf_mode = 2;
    exp_r = 8'h85;
`else
    puf_mode = 1;
    exp_r = 8'h7A;
`endif
    do_run(8'h01, 1'b0);
    checks++; if (resp_seen !== exp_r) begin errors++; $display("FAIL invert_response: got %h want %h", resp_seen, exp_r); end
    checks++; if (resp_seen !== model_resp(8'h01, puf_mode)) begin
      errors++; $display("FAIL invert_model: got %h want %h", resp_seen, model_resp(8'h01, puf_mode));
    end
    checks++; if (busy_cycles != BUSY_LEN) begin errors++; $display("FAIL invert_busy_len: got %0d want %0d", busy_cycles, BUSY_LEN); end
    $display("inverting_puf: mode=%0d response=%h busy=%0d", puf_mode, resp_seen, busy_cycles);
    puf_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_seed();
    test_start_while_busy();
    test_reset_mid_run();
    test_run_waveform();
    test_random_seeds();
    test_inverting_puf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
